id_imm_stage: RTL

- Decode-stage controller that configures and sequences the immediate generator.
- Classifies each fetched instruction's opcode into an immediate-format select and drives an internal imm_gen instance.
- Registers instruction, PC, immediate and select into the ID/EX pipeline register.
- Upstream (IF) and downstream (EX) use valid/ready handshakes; the stage also supports flush for branch/jump redirects.

---
 rtl/id_imm_stage_pkg.sv | 30 +++
 rtl/id_imm_stage_imm_gen.sv | 31 +++
 rtl/id_imm_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/id_imm_stage_pkg.sv
// Shared decode constants for the ID immediate stage: select codes, RV32 base
// opcodes and the machine word type.
package id_imm_stage_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_bus_t;
  localparam word_bus_t ZERO_WORD = '0;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

endpackage

// File: rtl/id_imm_stage_imm_gen.sv
// Combinational immediate generator: assembles the sign-extended immediate
// from instruction bits [31:7] for the given format select.
module imm_gen
  import id_imm_stage_pkg::*;
(
  input  logic      i_rst,
  input  logic [24:0] i_inst_hi,   // instruction bits [31:7]; index k holds inst[k+7]
  input  imm_sel_e  i_sel,
  output word_bus_t o_imm
);

  logic w_sign;
  assign w_sign = i_inst_hi[24];

  always_comb begin
    o_imm = ZERO_WORD;
    if (!i_rst) begin
      unique case (i_sel)
        IMM_I: o_imm = {{20{w_sign}}, i_inst_hi[24:13]};
        IMM_S: o_imm = {{20{w_sign}}, i_inst_hi[24:18], i_inst_hi[4:0]};
        IMM_B: o_imm = {{19{w_sign}}, w_sign, i_inst_hi[0], i_inst_hi[23:18],
                        i_inst_hi[4:1], 1'b0};
        IMM_U: o_imm = {i_inst_hi[24:5], 12'b0};
        IMM_J: o_imm = {{11{w_sign}}, w_sign, i_inst_hi[12:5], i_inst_hi[13],
                        i_inst_hi[23:14], 1'b0};
        default: o_imm = ZERO_WORD;
      endcase
    end
  end

endmodule

// File: rtl/id_imm_stage.sv
// Decode-stage immediate controller with an ID/EX pipeline register.
// Optional ex_illegal_o flag when ILLEGAL_OPCODE_EN is defined.
module id_imm_stage
  import id_imm_stage_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  input  logic [PC_W-1:0] if_pc_i,
  input  logic [31:0]     if_inst_i,
  output logic            id_ready_o,
  input  logic            flush_i,
  input  logic            ex_ready_i,
  output logic            ex_valid_o,
  output logic [PC_W-1:0] ex_pc_o,
  output logic [31:0]     ex_inst_o,
  output logic [2:0]      ex_imm_sel_o,
  output logic [31:0]     ex_imm_o
`ifdef ILLEGAL_OPCODE_EN
  ,
  output logic            ex_illegal_o
`endif
);

  // Handshake: a transfer happens on an edge where valid & ready are both high.
  // IF->ID: if_valid_i/id_ready_o; ID->EX: ex_valid_o/ex_ready_i. A producer
  // holding valid must keep its payload stable until the transfer edge.

  logic            r_valid;
  logic [PC_W-1:0] r_pc;
  word_bus_t       r_inst;
  imm_sel_e        r_sel;
  word_bus_t       r_imm;

  imm_sel_e  w_sel;
  word_bus_t w_imm;
  logic      w_accept;
  logic      w_release;

  always_comb begin
    w_sel = IMM_NONE;
    unique case (if_inst_i[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: w_sel = IMM_I;
      OP_STORE:                            w_sel = IMM_S;
      OP_BRANCH:                           w_sel = IMM_B;
      OP_LUI, OP_AUIPC:                    w_sel = IMM_U;
      OP_JAL:                              w_sel = IMM_J;
      default:                             w_sel = IMM_NONE;
    endcase
  end

  imm_gen u_imm_gen (
    .i_rst     (rst),
    .i_inst_hi (if_inst_i[31:7]),
    .i_sel     (w_sel),
    .o_imm     (w_imm)
  );

  assign id_ready_o = !r_valid || ex_ready_i;
  assign w_accept   = if_valid_i && id_ready_o && !flush_i;
  assign w_release  = r_valid && ex_ready_i;

  // Flush beats accept and stall; release only clears valid so data lingers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= ZERO_WORD;
      r_sel   <= IMM_NONE;
      r_imm   <= ZERO_WORD;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_pc    <= if_pc_i;
      r_inst  <= if_inst_i;
      r_sel   <= w_sel;
      r_imm   <= w_imm;
    end else if (w_release) begin
      r_valid <= 1'b0;
    end
  end

  assign ex_valid_o   = r_valid;
  assign ex_pc_o      = r_pc;
  assign ex_inst_o    = r_inst;
  assign ex_imm_sel_o = r_sel;
  assign ex_imm_o     = r_imm;

`ifdef ILLEGAL_OPCODE_EN
  logic w_illegal;
  logic r_illegal;

  always_comb begin
    w_illegal = 1'b1;
    unique case (if_inst_i[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_REG, OP_FENCE: w_illegal = 1'b0;
      default:                                    w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_illegal <= w_illegal;
    end
  end

  assign ex_illegal_o = r_illegal;
`endif

endmodule
